// File: rtl/mux_rr_arbiter_4.sv
// mux_rr_arbiter_4
// Round-robin arbiter that shares one 4:1 mux datapath between four
// valid/ready requesters and a single downstream sink. The winner keeps the
// mux for up to BURST transfers. It releases early if its valid drops. One
// IDLE bubble cycle always separates consecutive grants.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   per-requester valid (bit i = requester i)
//   in_data    packed requester data, requester i at [i*W +: W]
//   in_ready   per-requester ready, only the granted bit can be high
//   out_valid  downstream valid (in_valid of the granted requester)
//   out_data   downstream data (mux output selected by sel)
//   out_ready  downstream ready
//   sel        registered grant index / mux select
//   busy       high while a grant is held
module mux_rr_arbiter_4 #(
  parameter int W     = 4,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [1:0]     sel,
  output logic           busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] winner;
  logic       xfer;
  logic       last_beat;

  // Search ptr, ptr+1, ... (mod 4). Scanning from the far end down means the
  // last hit written is the closest set bit to ptr.
  always_comb begin
    winner = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[ptr_q + 2'(k)]) winner = ptr_q + 2'(k);
    end
  end

  // 4:1 data mux, driven in both states
  always_comb begin
    out_data = in_data[W-1:0];
    for (int i = 1; i < 4; i++) begin
      if (sel_q == 2'(i)) out_data = in_data[i*W +: W];
    end
  end

  assign busy      = (state_q == GRANT);
  assign out_valid = busy && in_valid[sel_q];
  assign in_ready  = (busy && out_ready) ? (4'b0001 << sel_q) : 4'b0000;
  assign sel       = sel_q;

  assign xfer      = out_valid && out_ready;
  assign last_beat = (cnt_q == 4'(BURST - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          sel_d   = winner;
          cnt_d   = 4'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!in_valid[sel_q]) begin
          // requester ran dry: end of burst without a transfer
          state_d = IDLE;
          ptr_d   = sel_q + 2'd1;
        end else if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          if (last_beat) begin
            state_d = IDLE;
            ptr_d   = sel_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register; reset wins over any transfer on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/mux_rr_arbiter_4.md
Name: mux_rr_arbiter_4

Overview:
- Shares one 4:1 mux datapath (4-bit data, 2-bit select) between four valid/ready requesters.
- Round-robin arbitration; the winner holds the mux for a burst of up to BURST transfers.
- Drives the mux select, forwards the selected requester's data and handshake to a single downstream sink.
- Sits between four producer blocks and one shared consumer.

Parameters:
- W, 4: data width of each requester and of out_data.
- BURST, 4: max transfers per grant, range 1..15.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_data  input  4*W  packed requester data; requester i occupies bits [i*W +: W].
- in_ready  output  4  per-requester ready.
- out_valid  output  1  downstream valid.
- out_data  output  W  downstream data.
- out_ready  input  1  downstream ready.
- sel  output  2  current mux select (registered grant index).
- busy  output  1  high while a grant is held.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- State: FSM {IDLE, GRANT}.
  - ptr: 2-bit round-robin pointer.
  - sel: 2-bit grant index.
  - cnt: 4-bit transfer counter.
- Reset (rst=1 at an edge): state=IDLE, ptr=0, sel=0, cnt=0.
  - Outputs the following cycle: busy=0, out_valid=0, in_ready=4'b0000, sel=0.
  - Reset mid-burst abandons the burst immediately; no transfer completes on that edge.
- IDLE:
  - busy=0, out_valid=0, in_ready=0.
  - out_data = in_data of requester sel (mux stays driven; the value is don't-care to the sink).
  - If any in_valid bit is set, the winner is the first set bit searching ptr, ptr+1, ... modulo 4.
  - Next edge: sel=winner, cnt=0, state=GRANT.
  - If no in_valid bit is set, stay in IDLE.
- GRANT:
  - busy=1.
  - out_valid = in_valid[sel], combinational.
  - out_data = in_data[sel], combinational through the 4:1 mux.
  - in_ready[sel] = out_ready; all other in_ready bits are 0.
  - A transfer occurs on an edge where out_valid && out_ready; cnt increments on it.
- Release from GRANT to IDLE; ptr = sel+1 mod 4 on the release edge. Release occurs when either:
  - a transfer occurs with cnt == BURST-1, or
  - in_valid[sel]==0 (the requester has no more data; no transfer that cycle).
- Latency:
  - Request seen in IDLE at cycle n → grant at cycle n+1 → first transfer no earlier than cycle n+1.
  - One bubble cycle (IDLE) between consecutive grants.
- Non-granted requesters:
  - See in_ready=0 and must hold valid/data; the arbiter never drops or duplicates a beat.
  - Requester valid must not fall before its transfer; a drop while granted is treated as end-of-burst.
- Simultaneous events: multiple requesters in IDLE are resolved purely by ptr order. Consequences:
  - After requester i is served, it has lowest priority next round.
  - No starvation: any waiting requester is granted within 3 other grants.
- Stall: out_ready=0 in GRANT holds sel, cnt and state indefinitely.
- Wrap-around: ptr and sel wrap 3 → 0.
- BURST=1: release after every transfer.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=4'b1111 → busy=0, out_valid=0, in_ready=0, sel=0 throughout. After rst falls: grant to requester 0 one cycle later.
- Single requester: in_valid=4'b0100, data=4'hA, out_ready=1, BURST=4 → sel=2 next cycle, 4 transfers of 4'hA, then 1 IDLE cycle, then re-grant to 2.
- Round robin: in_valid=4'b1111 constantly, out_ready=1, BURST=1 → grant order 0,1,2,3,0. Each grant gives exactly 1 transfer separated by 1 idle cycle.
- Backpressure: requester 1 granted, out_ready=0 for 5 cycles → in_ready=4'b0000, sel=1, cnt unchanged. Then out_ready=1 → 4 transfers complete, ptr=2.
- Early release: requester 3 granted, sends 2 beats then drops valid → release that cycle, ptr=0, next grant searches from 0.
- Reset mid-burst: assert rst after 2 of 4 beats → next cycle busy=0, ptr=0, in_ready=0.
